// File: rtl/serial_add_pkg.sv
// Shared state encoding for the bit-serial adder controller.
package serial_add_pkg;
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_add_ctrl_fa.sv
// 1-bit full-adder cell shared across all bit positions of the serial adder.
module fa (
  output logic s,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa cell, WIDTH cycles per add, LSB first.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port for two's-complement a-b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cy_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] ld_b;
  logic             ld_cy;
  logic             last_bit;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as a + ~b + 1; c_in is ignored when sub is set.
  assign ld_b  = sub ? ~b : b;
  assign ld_cy = sub ? 1'b1 : c_in;
`else
  assign ld_b  = b;
  assign ld_cy = c_in;
`endif

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  fa u_fa (
    .s     (fa_s),
    .c_out (fa_c),
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .c_in  (cy_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
      if (state_q == ST_IDLE && start) begin
        sa_q  <= a;
        sb_q  <= ld_b;
        cy_q  <= ld_cy;
        cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        // Result fills from the MSB so after WIDTH shifts bit 0 is the LSB.
        sum_q <= {fa_s, sum_q[WIDTH-1:1]};
        sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
        sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
        cy_q  <= fa_c;
        cnt_q <= cnt_q + 1'b1;
        if (last_bit) cout_q <= fa_c;
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, random ops vs model, corner sequences.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, c_in, sub_r;
  logic [W-1:0] a, b, sum;
  logic         busy, done, c_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; bit W of the result is c_out.
  function automatic logic [W:0] model(input logic [W-1:0] ma, mb, input logic mcin, msub);
    int r;
    if (msub) begin
      r = int'(ma) - int'(mb);
      return {(ma >= mb), r[W-1:0]};
    end
    r = int'(ma) + int'(mb) + int'(mcin);
    return r[W:0];
  endfunction

  task automatic wait_done(input int limit, output int cyc, output int bcnt);
    cyc = 0; bcnt = 0;
    while (!done && cyc < limit) begin
      bcnt += int'(busy);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] ia, ib, input logic icin, isub,
                       input logic [W-1:0] es, input logic ec);
    int lat, bc;
    @(negedge clk);
    a = ia; b = ib; c_in = icin; sub_r = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    check({name, "_busy_after_start"}, busy, 1);
    wait_done(40, lat, bc);
    check({name, "_latency"}, lat + 1, W + 1);
    check({name, "_busy_cycles"}, bc, W);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, c_out, ec);
    @(negedge clk);
    check({name, "_done_width"}, done, 0);
    check({name, "_sum_hold"}, sum, es);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W:0] m;
    logic [W-1:0] ra, rb, exp_s[$];
    logic exp_c[$];
    int lat, bc, dcount;

    vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    // Reset dominates a simultaneous start.
    rst = 1'b1; start = 1'b1; a = 8'hAB; b = 8'hCD; c_in = 1'b1; sub_r = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", c_out, 0);
    rst = 1'b0; start = 1'b0;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].es, vecs[i].ec);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      sub_r = 1'($urandom);
`else
      sub_r = 1'b0;
`endif
      c_in = 1'($urandom);
      m = model(ra, rb, c_in, sub_r);
      do_op($sformatf("rnd%0d", i), ra, rb, c_in, sub_r, m[W-1:0], m[W]);
    end

    // Start during RUN and held through DONE is ignored until IDLE.
    @(negedge clk);
    a = 8'h12; b = 8'h34; c_in = 1'b0; sub_r = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    wait_done(40, lat, bc);
    check("ign_latency", lat + 3, W + 1);
    check("ign_sum", sum, 8'h46);
    check("ign_cout", c_out, 0);
    @(negedge clk);
    check("ign_done_idle", done, 0);
    check("ign_busy_idle", busy, 0);
    @(negedge clk);
    check("ign_accept_idle", busy, 1);
    start = 1'b0;
    wait_done(40, lat, bc);
    check("ign2_latency", lat + 1, W + 1);
    check("ign2_sum", sum, 8'hFF);
    check("ign2_cout", c_out, 0);
    @(negedge clk);

    // Reset in the middle of RUN aborts the operation.
    a = 8'h0F; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", c_out, 0);
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      dcount += int'(done) + int'(busy);
    end
    check("mid_rst_no_done", dcount, 0);
    do_op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

    // Back-to-back with start held high: new op every W+2 cycles.
    @(negedge clk);
    ra = W'($urandom); rb = W'($urandom);
    a = ra; b = rb; c_in = 1'($urandom); sub_r = 1'b0; start = 1'b1;
    m = model(ra, rb, c_in, 1'b0);
    exp_s.push_back(m[W-1:0]); exp_c.push_back(m[W]);
    @(negedge clk);
    wait_done(40, lat, bc);
    check("b2b_first_latency", lat + 1, W + 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_done(40, lat, bc);
        check($sformatf("b2b%0d_interval", k), lat + 1, W + 2);
      end
      check($sformatf("b2b%0d_sum", k), sum, exp_s.pop_front());
      check($sformatf("b2b%0d_cout", k), c_out, exp_c.pop_front());
      ra = W'($urandom); rb = W'($urandom);
      a = ra; b = rb; c_in = 1'($urandom);
      m = model(ra, rb, c_in, 1'b0);
      exp_s.push_back(m[W-1:0]); exp_c.push_back(m[W]);
      @(negedge clk);
      check($sformatf("b2b%0d_done_width", k), done, 0);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
